// File: rtl/bcd_seq_multiplier_if.sv
// Bus between a requester and the digit-serial BCD multiplier core.
//
// Handshake: the requester raises start together with operands a and b.
// The core samples start only while idle. On acceptance it captures a and b,
// so the requester may change them or drop start afterwards. busy is high
// while digits are being processed. done pulses for exactly one cycle when
// product and err are final. Both then hold until the next accepted start.
// If start is still high on the first idle cycle after done, that cycle
// accepts a new operation.
interface bcd_seq_multiplier_if #(
    parameter int DIGITS = 8
);
    logic                  start;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [8*DIGITS-1:0]   product;
    logic [1:0]            fsm_state;   // debug view of the controller state

    modport master (
        output start, a, b,
        input  busy, done, err, product, fsm_state
    );

    modport slave (
        input  start, a, b,
        output busy, done, err, product, fsm_state
    );
endinterface

// File: rtl/bcd_seq_multiplier.sv
// Digit-serial packed-BCD multiplier. It processes one multiplier digit per
// clock and accumulates the shifted partial products A*B[k] into a
// 2*DIGITS-digit BCD accumulator. That accumulator is also the product output.
module bcd_seq_multiplier #(
    parameter int DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_seq_multiplier_if.slave bus
);
    localparam int OPW  = 4 * DIGITS;
    localparam int ACCW = 8 * DIGITS;
    localparam int PW   = 4 * (DIGITS + 1);
    localparam int KW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [OPW-1:0]    a_q, b_q;
    logic [ACCW-1:0]   acc, acc_sum;
    logic [KW-1:0]     k;
    logic              err_q;
    logic              ops_ok, accept, last_digit;
    logic [3:0]        b_dig;
    logic [PW-1:0]     pp;
    logic [ACCW-1:0]   pp_sh;

    // True when every nibble of an operand is a legal decimal digit.
    function automatic logic all_bcd(input logic [OPW-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Single digit x digit product returned as two BCD digits {H, L}.
    function automatic logic [7:0] digit_mul(input logic [3:0] x, input logic [3:0] y);
        logic [6:0] m;
        m = 7'(x) * 7'(y);
        return {4'(m / 7'd10), 4'(m % 7'd10)};
    endfunction

    assign ops_ok     = all_bcd(bus.a) && all_bcd(bus.b);
    assign accept     = (state == ST_IDLE) && bus.start;
    assign last_digit = (k == KW'(DIGITS - 1));

    // Select the multiplier digit for the current step.
    always_comb begin
        b_dig = '0;
        for (int i = 0; i < DIGITS; i++)
            if (k == KW'(i)) b_dig = b_q[4*i +: 4];
    end

    // Partial product A*B[k]: per-digit {H,L}, then decimal carry ripple.
    // Digit i collects L_i + H_(i-1) + carry, which is at most 18. The top
    // digit is H_(DIGITS-1) + carry, which cannot exceed 9.
    always_comb begin : pp_ripple
        logic [7:0] hl;
        logic [3:0] hi_prev;
        logic [4:0] s;
        logic       c;
        pp      = '0;
        hl      = '0;
        hi_prev = '0;
        s       = '0;
        c       = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            hl = digit_mul(a_q[4*i +: 4], b_dig);
            s  = 5'(hl[3:0]) + 5'(hi_prev) + 5'(c);
            if (s > 5'd9) begin
                pp[4*i +: 4] = 4'(s - 5'd10);
                c = 1'b1;
            end else begin
                pp[4*i +: 4] = s[3:0];
                c = 1'b0;
            end
            hi_prev = hl[7:4];
        end
        pp[4*DIGITS +: 4] = hi_prev + 4'(c);
    end

    // Align the partial product to accumulator digit k.
    always_comb begin
        pp_sh = '0;
        for (int i = 0; i < DIGITS; i++)
            if (k == KW'(i)) pp_sh = ACCW'(pp) << (4 * i);
    end

    // BCD adder chain across the whole accumulator. Digits below k add zero.
    // The carry ripples past digit k+DIGITS into the upper digits.
    always_comb begin : bcd_add
        logic [4:0] s;
        logic       c;
        acc_sum = '0;
        s       = '0;
        c       = 1'b0;
        for (int j = 0; j < 2 * DIGITS; j++) begin
            s = 5'(acc[4*j +: 4]) + 5'(pp_sh[4*j +: 4]) + 5'(c);
            if (s > 5'd9) begin
                acc_sum[4*j +: 4] = 4'(s + 5'd6);
                c = 1'b1;
            end else begin
                acc_sum[4*j +: 4] = s[3:0];
                c = 1'b0;
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_n;
    end

    // Next-state logic. Invalid operands skip MULT and report at once.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: if (bus.start) state_n = ops_ok ? ST_MULT : ST_DONE;
            ST_MULT: if (last_digit) state_n = ST_DONE;
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Operand capture, accumulation and digit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            k     <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            a_q   <= bus.a;
            b_q   <= bus.b;
            acc   <= '0;
            k     <= '0;
            err_q <= !ops_ok;
        end else if (state == ST_MULT) begin
            acc <= acc_sum;
            k   <= k + KW'(1);
        end
    end

    assign bus.busy      = (state == ST_MULT);
    assign bus.done      = (state == ST_DONE);
    assign bus.err       = err_q;
    assign bus.product   = acc;
    assign bus.fsm_state = state;
endmodule
